// File: rtl/serial_parity_pkg.sv
// Shared types for the serial parity framer: frame FSM states and mode encodings.
package serial_parity_pkg;

   typedef enum logic [1:0] {
      StData,
      StGenPar,
      StChkPar
   } state_e;

   localparam logic MODE_GEN = 1'b0;
   localparam logic MODE_CHK = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [Width-1:0] count_o
);

   logic [Width-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != {Width{1'b1}})) begin
         count_d = count_q + Width'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/serial_parity_framer.sv
// Serial parity framer: forwards DATA_W-bit frames and either appends a parity bit
// (generate) or consumes and verifies a trailing parity bit (check).
module serial_parity_framer
   import serial_parity_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter bit          ODD    = 1'b0,
   parameter int unsigned ERR_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             mode,
   input  logic             x,
   input  logic             x_valid,
   output logic             x_ready,
   output logic             z,
   output logic             out_bit,
   output logic             out_valid,
   output logic             frame_end,
   output logic             par_err,
   output logic [ERR_W-1:0] err_count
);

   localparam int unsigned CNT_W = $clog2(DATA_W + 1);

   state_e           state_d, state_q;
   logic [CNT_W-1:0] bit_cnt_d, bit_cnt_q;
   logic             acc_d, acc_q;
   logic             mode_d, mode_q;
   logic             out_bit_d, out_bit_q;
   logic             out_valid_d, out_valid_q;
   logic             frame_end_d, frame_end_q;
   logic             par_err_d, par_err_q;
   logic             err_inc;
   logic             accept;
   logic             mode_eff;

   assign x_ready = (state_q != StGenPar);
   assign accept  = x_valid && x_ready;
   // With DATA_W = 1 the first bit is also the last, so use the live mode there.
   assign mode_eff = (bit_cnt_q == '0) ? mode : mode_q;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      acc_d       = acc_q;
      mode_d      = mode_q;
      out_bit_d   = out_bit_q;
      out_valid_d = 1'b0;
      frame_end_d = 1'b0;
      par_err_d   = 1'b0;
      err_inc     = 1'b0;

      if (clr) begin
         state_d   = StData;
         bit_cnt_d = '0;
         acc_d     = 1'b0;
      end else begin
         unique case (state_q)
            StData: begin
               if (accept) begin
                  mode_d      = mode_eff;
                  acc_d       = acc_q ^ x;
                  out_bit_d   = x;
                  out_valid_d = 1'b1;
                  if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                     bit_cnt_d = '0;
                     state_d   = (mode_eff == MODE_CHK) ? StChkPar : StGenPar;
                  end else begin
                     bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  end
               end
            end
            StGenPar: begin
               out_bit_d   = acc_q ^ ODD;
               out_valid_d = 1'b1;
               frame_end_d = 1'b1;
               acc_d       = 1'b0;
               state_d     = StData;
            end
            StChkPar: begin
               if (accept) begin
                  frame_end_d = 1'b1;
                  par_err_d   = (x != (acc_q ^ ODD));
                  err_inc     = par_err_d;
                  acc_d       = 1'b0;
                  state_d     = StData;
               end
            end
            default: state_d = StData;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StData;
         bit_cnt_q   <= '0;
         acc_q       <= 1'b0;
         mode_q      <= 1'b0;
         out_bit_q   <= 1'b0;
         out_valid_q <= 1'b0;
         frame_end_q <= 1'b0;
         par_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         acc_q       <= acc_d;
         mode_q      <= mode_d;
         out_bit_q   <= out_bit_d;
         out_valid_q <= out_valid_d;
         frame_end_q <= frame_end_d;
         par_err_q   <= par_err_d;
      end
   end

   sat_counter #(
      .Width(ERR_W)
   ) u_err_cnt (
      .clk_i  (clk),
      .rst_i  (rst),
      .clr_i  (clr),
      .inc_i  (err_inc),
      .count_o(err_count)
   );

   assign z         = acc_q ^ ODD;
   assign out_bit   = out_bit_q;
   assign out_valid = out_valid_q;
   assign frame_end = frame_end_q;
   assign par_err   = par_err_q;

endmodule

// File: tb/tb_serial_parity_framer.sv
// Directed bench: three DATA_W=6 instances (even, odd, 2-bit error counter) share stimulus;
// a fourth DATA_W=1 instance covers the single-bit frame corner.
module tb_serial_parity_framer;

   logic clk, rst, clr, mode, x, x_valid;
   logic mode3, x3, xv3;

   logic       rdy0, z0, ob0, ov0, fe0, pe0;
   logic [7:0] ec0;
   logic       rdy1, z1, ob1, ov1, fe1, pe1;
   logic [7:0] ec1;
   logic       rdy2, z2, ob2, ov2, fe2, pe2;
   logic [1:0] ec2;
   logic       rdy3, z3, ob3, ov3, fe3, pe3;
   logic [7:0] ec3;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   logic        acc;
   int unsigned e0, e1, e2;

   serial_parity_framer #(.DATA_W(6), .ODD(1'b0), .ERR_W(8)) dut0 (
      .clk(clk), .rst(rst), .clr(clr), .mode(mode), .x(x), .x_valid(x_valid),
      .x_ready(rdy0), .z(z0), .out_bit(ob0), .out_valid(ov0), .frame_end(fe0),
      .par_err(pe0), .err_count(ec0));

   serial_parity_framer #(.DATA_W(6), .ODD(1'b1), .ERR_W(8)) dut1 (
      .clk(clk), .rst(rst), .clr(clr), .mode(mode), .x(x), .x_valid(x_valid),
      .x_ready(rdy1), .z(z1), .out_bit(ob1), .out_valid(ov1), .frame_end(fe1),
      .par_err(pe1), .err_count(ec1));

   serial_parity_framer #(.DATA_W(6), .ODD(1'b0), .ERR_W(2)) dut2 (
      .clk(clk), .rst(rst), .clr(clr), .mode(mode), .x(x), .x_valid(x_valid),
      .x_ready(rdy2), .z(z2), .out_bit(ob2), .out_valid(ov2), .frame_end(fe2),
      .par_err(pe2), .err_count(ec2));

   serial_parity_framer #(.DATA_W(1), .ODD(1'b0), .ERR_W(8)) dut3 (
      .clk(clk), .rst(rst), .clr(1'b0), .mode(mode3), .x(x3), .x_valid(xv3),
      .x_ready(rdy3), .z(z3), .out_bit(ob3), .out_valid(ov3), .frame_end(fe3),
      .par_err(pe3), .err_count(ec3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One accepted data bit, checked one cycle later on out_bit.
   task automatic send(input logic b);
      check("x_ready_data", rdy0, 1'b1);
      x       = b;
      x_valid = 1'b1;
      tick();
      x_valid = 1'b0;
      acc     = acc ^ b;
      check("out_valid_data", ov0, 1'b1);
      check("out_bit_data", ob0, b);
      check("out_bit_odd", ob1, b);
      check("frame_end_data", fe0, 1'b0);
      check("z_even", z0, acc);
      check("z_odd", z1, !acc);
      check("z_err2", z2, acc);
   endtask

   task automatic idle();
      x       = 1'b1;
      x_valid = 1'b0;
      tick();
      check("out_valid_idle", ov0, 1'b0);
      check("x_ready_idle", rdy0, 1'b1);
      check("frame_end_idle", fe0, 1'b0);
   endtask

   // Parity insertion cycle; a bit offered meanwhile must not be taken.
   task automatic gen_end(input logic exp_par);
      check("x_ready_genpar", rdy0, 1'b0);
      check("x_ready_genpar_odd", rdy1, 1'b0);
      x       = 1'b1;
      x_valid = 1'b1;
      tick();
      x_valid = 1'b0;
      check("out_valid_par", ov0, 1'b1);
      check("par_even", ob0, exp_par);
      check("par_odd", ob1, !exp_par);
      check("frame_end_gen", fe0, 1'b1);
      check("frame_end_gen_odd", fe1, 1'b1);
      check("z_even_after", z0, 1'b0);
      check("z_odd_after", z1, 1'b1);
      check("x_ready_after", rdy0, 1'b1);
      acc = 1'b0;
   endtask

   task automatic chk_end(input logic p, input logic exp_par);
      check("x_ready_chkpar", rdy0, 1'b1);
      x       = p;
      x_valid = 1'b1;
      tick();
      x_valid = 1'b0;
      if (p != exp_par) e0 = (e0 == 255) ? 255 : e0 + 1;
      if (p == exp_par) e1 = (e1 == 255) ? 255 : e1 + 1;
      if (p != exp_par) e2 = (e2 == 3) ? 3 : e2 + 1;
      check("out_valid_chk", ov0, 1'b0);
      check("frame_end_chk", fe0, 1'b1);
      check("par_err_even", pe0, (p != exp_par));
      check("par_err_odd", pe1, (p == exp_par));
      check("err_count_even", ec0, e0);
      check("err_count_odd", ec1, e1);
      check("err_count_sat", ec2, e2);
      check("z_chk_after", z0, 1'b0);
      acc = 1'b0;
   endtask

   task automatic send6(input logic [5:0] d);
      for (int i = 5; i >= 0; i--) send(d[i]);
   endtask

   task automatic do_clr(input logic offer);
      clr     = 1'b1;
      x       = 1'b1;
      x_valid = offer;
      tick();
      clr     = 1'b0;
      x_valid = 1'b0;
      e0 = 0; e1 = 0; e2 = 0; acc = 1'b0;
      check("clr_out_valid", ov0, 1'b0);
      check("clr_frame_end", fe0, 1'b0);
      check("clr_par_err", pe0, 1'b0);
      check("clr_err_count", ec0, 0);
      check("clr_err_count_sat", ec2, 0);
      check("clr_z", z0, 1'b0);
      check("clr_x_ready", rdy0, 1'b1);
   endtask

   task automatic check_reset();
      check("rst_out_bit", ob0, 1'b0);
      check("rst_out_valid", ov0, 1'b0);
      check("rst_frame_end", fe0, 1'b0);
      check("rst_par_err", pe0, 1'b0);
      check("rst_err_count", ec0, 0);
      check("rst_err_count_sat", ec2, 0);
      check("rst_z_even", z0, 1'b0);
      check("rst_z_odd", z1, 1'b1);
      check("rst_x_ready", rdy0, 1'b1);
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; mode = 1'b0; x = 1'b0; x_valid = 1'b0;
      mode3 = 1'b0; x3 = 1'b0; xv3 = 1'b0;
      acc = 1'b0; e0 = 0; e1 = 0; e2 = 0;
      #3;
      check_reset();
      #9;
      rst = 1'b0;

      // Generate mode: 1,0,0,1,0,1 -> even parity 1, odd parity 0
      mode = 1'b0;
      send6(6'b100101);
      gen_end(1'b1);

      // Check mode: correct then wrong parity
      mode = 1'b1;
      send6(6'b100101);
      chk_end(1'b1, 1'b1);
      send6(6'b100101);
      chk_end(1'b0, 1'b1);

      // Saturating counter: five bad frames on a 2-bit counter
      do_clr(1'b0);
      for (int k = 0; k < 5; k++) begin
         logic [1:0] exp_sat [5];
         exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
         send6(6'b100101);
         chk_end(1'b0, 1'b1);
         check("err_sat_table", ec2, exp_sat[k]);
      end
      do_clr(1'b0);

      // clr mid-frame discards partial frame and the bit offered with it
      mode = 1'b0;
      send(1'b1);
      send(1'b0);
      do_clr(1'b1);
      send6(6'b100101);
      gen_end(1'b1);

      // Gaps plus a mid-frame mode change
      mode = 1'b0;
      send(1'b1);
      send(1'b1);
      mode = 1'b1;
      idle();
      idle();
      idle();
      for (int i = 0; i < 4; i++) send(1'b0);
      gen_end(1'b0);

      // Build up an error, then reset mid-frame
      mode = 1'b1;
      send6(6'b111000);
      chk_end(1'b0, 1'b1);
      mode = 1'b0;
      send(1'b1);
      send(1'b0);
      send(1'b1);
      rst = 1'b1;
      #2;
      check_reset();
      #2;
      rst = 1'b0;
      acc = 1'b0; e0 = 0; e1 = 0; e2 = 0;
      send6(6'b111000);
      gen_end(1'b1);

      // DATA_W = 1: every data bit is followed by its parity cycle
      mode3 = 1'b0; xv3 = 1'b1; x3 = 1'b1;
      tick();
      check("w1_bit", ob3, 1'b1);
      check("w1_valid", ov3, 1'b1);
      check("w1_ready_low", rdy3, 1'b0);
      check("w1_fe_data", fe3, 1'b0);
      x3 = 1'b0;
      tick();
      check("w1_par1", ob3, 1'b1);
      check("w1_fe_par1", fe3, 1'b1);
      check("w1_ready_high", rdy3, 1'b1);
      tick();
      check("w1_bit0", ob3, 1'b0);
      check("w1_fe_bit0", fe3, 1'b0);
      tick();
      check("w1_par0", ob3, 1'b0);
      check("w1_fe_par0", fe3, 1'b1);
      mode3 = 1'b1; x3 = 1'b1;
      tick();
      check("w1_chk_bit", ob3, 1'b1);
      check("w1_chk_ready", rdy3, 1'b1);
      x3 = 1'b0;
      tick();
      xv3 = 1'b0;
      check("w1_chk_fe", fe3, 1'b1);
      check("w1_chk_valid", ov3, 1'b0);
      check("w1_chk_err", pe3, 1'b1);
      check("w1_chk_cnt", ec3, 1);
      check("w1_z", z3, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
